// File: rtl/idma_nd_unroll_2d.sv
// 2D-to-1D transfer unroller: splits one strided job into bursts.
// Option IDMA_ND_UNROLL_ZERO_LEN_SKIP_EN: zero-length jobs issue no bursts.
module idma_nd_unroll_2d #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned RepWidth       = 16,
  parameter int unsigned NumOutstanding = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 nd_req_valid_i,
  output logic                 nd_req_ready_o,
  input  logic [AddrWidth-1:0] nd_src_addr_i,
  input  logic [AddrWidth-1:0] nd_dst_addr_i,
  input  logic [AddrWidth-1:0] nd_length_i,
  input  logic [AddrWidth-1:0] nd_src_stride_i,
  input  logic [AddrWidth-1:0] nd_dst_stride_i,
  input  logic [RepWidth-1:0]  nd_num_reps_i,
  output logic                 burst_req_valid_o,
  input  logic                 burst_req_ready_i,
  output logic [AddrWidth-1:0] burst_src_addr_o,
  output logic [AddrWidth-1:0] burst_dst_addr_o,
  output logic [AddrWidth-1:0] burst_length_o,
  input  logic                 burst_rsp_valid_i,
  output logic                 burst_rsp_ready_o,
  input  logic                 burst_rsp_error_i,
  output logic                 nd_rsp_valid_o,
  input  logic                 nd_rsp_ready_i,
  output logic                 nd_rsp_error_o,
  output logic                 busy_o
);

  localparam int unsigned CntWidth = $clog2(NumOutstanding + 1);
  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(NumOutstanding);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_e;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] src_q, dst_q, len_q;
  logic [AddrWidth-1:0] src_stride_q, dst_stride_q;
  logic [RepWidth-1:0]  rem_q;
  logic [CntWidth-1:0]  cnt_q;
  logic                 err_q;
  logic                 nd_hs, req_hs, rsp_hs, skip;

  // Outputs are forced low while reset is held, regardless of old state.
  assign nd_req_ready_o    = ~rst_i & (state_q == IDLE);
  assign burst_req_valid_o = ~rst_i & (state_q == ISSUE) & (cnt_q < MaxCnt);
  assign burst_rsp_ready_o = ~rst_i & (cnt_q != '0);
  assign nd_rsp_valid_o    = ~rst_i & (state_q == RESP);
  assign nd_rsp_error_o    = ~rst_i & (state_q == RESP) & err_q;
  assign busy_o            = ~rst_i & (state_q != IDLE);
  assign burst_src_addr_o  = rst_i ? '0 : src_q;
  assign burst_dst_addr_o  = rst_i ? '0 : dst_q;
  assign burst_length_o    = rst_i ? '0 : len_q;

  assign nd_hs  = nd_req_valid_i & nd_req_ready_o;
  assign req_hs = burst_req_valid_o & burst_req_ready_i;
  assign rsp_hs = burst_rsp_valid_i & burst_rsp_ready_o;

`ifdef IDMA_ND_UNROLL_ZERO_LEN_SKIP_EN
  assign skip = (nd_num_reps_i == '0) | (nd_length_i == '0);
`else
  assign skip = (nd_num_reps_i == '0);
`endif

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: one job walks IDLE -> ISSUE -> DRAIN -> RESP.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (nd_hs) state_d = skip ? RESP : ISSUE;
      ISSUE: if (req_hs && rem_q == RepWidth'(1)) state_d = DRAIN;
      DRAIN: if (cnt_q == '0) state_d = RESP;
      RESP:  if (nd_rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Job registers: latch on accept, step addresses on each burst.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      src_stride_q <= '0;
      dst_stride_q <= '0;
      rem_q        <= '0;
      err_q        <= 1'b0;
    end else if (nd_hs) begin
      src_q        <= nd_src_addr_i;
      dst_q        <= nd_dst_addr_i;
      len_q        <= nd_length_i;
      src_stride_q <= nd_src_stride_i;
      dst_stride_q <= nd_dst_stride_i;
      rem_q        <= nd_num_reps_i;
      err_q        <= 1'b0;
    end else begin
      if (req_hs) begin
        src_q <= src_q + src_stride_q;
        dst_q <= dst_q + dst_stride_q;
        rem_q <= rem_q - RepWidth'(1);
      end
      if (rsp_hs) err_q <= err_q | burst_rsp_error_i;
    end
  end

  // In-flight burst counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      unique case ({req_hs, rsp_hs})
        2'b10:   cnt_q <= cnt_q + CntWidth'(1);
        2'b01:   cnt_q <= cnt_q - CntWidth'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: doc/idma_nd_unroll_2d.md
IDMA_ND_UNROLL_2D -- requirements
Module: idma_nd_unroll_2d

Interface
REQ-001 The block SHALL have parameter AddrWidth, default 32: width of addresses, lengths and strides.
REQ-002 The block SHALL have parameter RepWidth, default 16: width of the repetition count.
REQ-003 The block SHALL have parameter NumOutstanding, default 2, minimum 1: maximum number of 1D bursts in flight.
REQ-004 The block SHALL provide the following ports (name, direction, width, meaning):
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  reset; synchronous, active-high.
- nd_req_valid_i  in  1  2D request valid.
- nd_req_ready_o  out  1  2D request ready.
- nd_src_addr_i / nd_dst_addr_i  in  AddrWidth  base addresses.
- nd_length_i  in  AddrWidth  bytes per burst.
- nd_src_stride_i / nd_dst_stride_i  in  AddrWidth  per-repetition increments.
- nd_num_reps_i  in  RepWidth  number of bursts.
- burst_req_valid_o  out  1  1D request valid.
- burst_req_ready_i  in  1  1D request ready.
- burst_src_addr_o / burst_dst_addr_o  out  AddrWidth  1D addresses.
- burst_length_o  out  AddrWidth  1D length.
- burst_rsp_valid_i  in  1  1D response valid.
- burst_rsp_ready_o  out  1  1D response ready.
- burst_rsp_error_i  in  1  1D response error flag.
- nd_rsp_valid_o  out  1  2D completion valid.
- nd_rsp_ready_i  in  1  2D completion ready.
- nd_rsp_error_o  out  1  OR of all burst errors of the job.
- busy_o  out  1  high in any state other than IDLE.

Function
REQ-005 The FSM SHALL have the states IDLE, ISSUE, DRAIN and RESP; exactly one 2D job is processed at a time.
REQ-006 nd_req_ready_o SHALL be 1 only in IDLE; a transfer on valid&ready SHALL latch all nd_* fields, clear the error flag, set the remaining-repetition count to nd_num_reps_i, and move to ISSUE (or to RESP if nd_num_reps_i==0).
REQ-007 In ISSUE, burst_req_valid_o SHALL be 1 iff the in-flight count is below NumOutstanding; the first valid SHALL be asserted in the cycle after acceptance.
REQ-008 Burst k (0-based) SHALL carry src = src_base + k*src_stride and dst = dst_base + k*dst_stride, computed incrementally and wrapping modulo 2^AddrWidth; burst_length_o SHALL equal the latched length.
REQ-009 The burst outputs SHALL stay stable while burst_req_valid_o=1 and burst_req_ready_i=0.
REQ-010 On each burst handshake, the remaining count SHALL decrement; when it reaches 0, the FSM SHALL move to DRAIN.
REQ-011 burst_rsp_ready_o SHALL be 1 iff the in-flight count is greater than 0; a response with ready low SHALL be ignored.
REQ-012 The in-flight count SHALL increment on a request handshake and decrement on a response handshake; if both occur in the same cycle, the count SHALL remain unchanged.
REQ-013 Each accepted response SHALL OR burst_rsp_error_i into the sticky error flag.
REQ-014 DRAIN SHALL move to RESP in the cycle after the in-flight count reaches 0.
REQ-015 In RESP, nd_rsp_valid_o SHALL be 1 and nd_rsp_error_o SHALL equal the flag; on nd_rsp_ready_i the FSM SHALL return to IDLE, and nd_rsp_* SHALL stay stable until then.

Reset
REQ-016 While rst_i=1, the FSM SHALL be in IDLE, all counters and the error flag SHALL be 0, and all outputs SHALL be 0 except nd_req_ready_o, which SHALL be 0 during reset and 1 in the first cycle after.
REQ-017 A reset asserted mid-job SHALL abandon the job, and responses arriving afterwards SHALL be ignored.

Configuration
REQ-018 With macro IDMA_ND_UNROLL_ZERO_LEN_SKIP_EN defined, a request with nd_length_i==0 SHALL go straight to RESP with error 0 and issue no bursts; without the macro, it SHALL issue nd_num_reps_i zero-length bursts normally.

Verification
REQ-019 Scenario: src=0x1000, dst=0x8000, len=64, strides 0x100/0x40, reps=3, ready tied 1 -> bursts (0x1000,0x8000), (0x1100,0x8040), (0x1200,0x8080), then exactly one nd_rsp, error=0.
REQ-020 Scenario: NumOutstanding=2, reps=4, responses withheld -> exactly 2 bursts issued and valid held low; each response releases one more burst.
REQ-021 Scenario: reps=3, second burst response has error=1 -> nd_rsp_error_o=1; the next job reports error=0.
REQ-022 Scenario: src=0xFFFF_FFC0, stride 0x80, reps=2 -> second src=0x0000_0040 (wrap).
REQ-023 Scenario: reps=0 -> no bursts and nd_rsp in the cycle after acceptance; len=0 with reps=2 -> 0 bursts with the macro defined, 2 bursts without it.
REQ-024 Scenario: rst_i pulsed after the first burst of reps=4 -> IDLE, busy_o=0, a late response ignored, and the next job runs correctly.
